// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the round-robin shared-adder block.
package adder_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREQ  = 4;

  // Result register occupancy: EMPTY means rsp_valid low, FULL means a sum is held.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Plain WIDTH-bit adder with carry-out; the one adder shared by all requesters.
module adder_arbiter_adder
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  // Zero-extend both operands so the top bit of the sum is the carry-out.
  assign {carry, y} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared adder with a single result register.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREQ  = DEFAULT_NREQ,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic                       rsp_carry,
  output logic [IDW-1:0]             rsp_id
);

  localparam int IDW1 = IDW + 1;

  state_t               state_reg, state_next;
  logic [IDW-1:0]       ptr_reg, ptr_next;
  logic [WIDTH-1:0]     y_reg;
  logic                 carry_reg;
  logic [IDW-1:0]       id_reg;

  logic [NREQ-1:0][IDW-1:0] cand_idx;
  logic [NREQ-1:0]          cand_valid;
  logic                     grant_found;
  logic [IDW-1:0]           grant_idx;
  logic                     can_accept;
  logic                     transfer;
  logic [WIDTH-1:0]         sum_y;
  logic                     sum_carry;

  // Candidate gi is the requester gi places after the pointer, wrapped modulo NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW1-1:0] raw;
      assign raw            = {1'b0, ptr_reg} + IDW1'(gi);
      assign cand_idx[gi]   = (raw >= IDW1'(NREQ)) ? IDW'(raw - IDW1'(NREQ)) : raw[IDW-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Pick the first valid candidate; scanning downward lets the lowest offset win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // A new operand pair fits when the result slot is empty or is draining this cycle.
  assign can_accept = (state_reg == EMPTY) || rsp_ready;
  assign transfer   = reset && can_accept && grant_found;
  assign ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // One-hot accept strobe, forced low while reset is held.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = transfer && (grant_idx == IDW'(gi));
    end
  endgenerate

  adder_arbiter_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (req_a[grant_idx]),
    .b     (req_b[grant_idx]),
    .y     (sum_y),
    .carry (sum_carry)
  );

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Next occupancy: fill on transfer, drain on rsp_ready unless refilled in the same edge.
  always_comb begin
    state_next = state_reg;
    rsp_valid  = (state_reg == FULL);
    case (state_reg)
      EMPTY:   if (transfer) state_next = FULL;
      FULL:    if (rsp_ready && !transfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Result and pointer capture; everything holds unless a transfer completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_reg     <= '0;
      carry_reg <= 1'b0;
      id_reg    <= '0;
      ptr_reg   <= '0;
    end else if (transfer) begin
      y_reg     <= sum_y;
      carry_reg <= sum_carry;
      id_reg    <= grant_idx;
      ptr_reg   <= ptr_next;
    end
  end

  assign rsp_y     = y_reg;
  assign rsp_carry = carry_reg;
  assign rsp_id    = id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scenario bench for adder_arbiter with a scoreboard of expected results.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0][W-1:0] req_a = '0;
  logic [N-1:0][W-1:0] req_b = '0;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [W-1:0]       rsp_y;
  logic               rsp_carry;
  logic [IW-1:0]      rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          carry;
    logic [W-1:0]  y;
  } exp_t;

  exp_t sb[$];

  adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each accepted result is popped and compared.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (reset && rsp_valid && rsp_ready) begin
      act = {rsp_id, rsp_carry, rsp_y};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d y=%h c=%b, want no result", rsp_id, rsp_y, rsp_carry);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_result: got id=%0d c=%b y=%h, want id=%0d c=%b y=%h",
                   act.id, act.carry, act.y, e.id, e.carry, e.y);
        end else begin
          $display("rsp id=%0d y=%h carry=%b", act.id, act.y, act.carry);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id);
    exp_t e;
    logic [W:0] s;
    s = {1'b0, req_a[id]} + {1'b0, req_b[id]};
    e.id    = IW'(id);
    e.carry = s[W];
    e.y     = s[W-1:0];
    sb.push_back(e);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = W'($urandom_range(0, 255));
      req_b[i] = W'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    rand_ops();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++;
    if ({rsp_valid, rsp_carry, rsp_id, rsp_y} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b c=%b id=%0d y=%h want all 0", rsp_valid, rsp_carry, rsp_id, rsp_y);
    end
    $display("reset held: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
    next_cycle();
    reset = 1'b1;
    req_valid = '0;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_a[0] = 8'h12;
    req_b[0] = 8'h34;
    rsp_ready = 1'b1;
    push(0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_carry, rsp_id, rsp_y} !== {1'b1, 1'b0, 2'd0, 8'h46}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b c=%b id=%0d y=%h want v=1 c=0 id=0 y=46", rsp_valid, rsp_carry, rsp_id, rsp_y);
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    req_valid = 4'b0100;
    req_a[2] = 8'hFF;
    req_b[2] = 8'h01;
    push(2);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if ({rsp_carry, rsp_id, rsp_y} !== {1'b1, 2'd2, 8'h00}) begin
      errors++;
      $display("FAIL ovf_rsp: got c=%b id=%0d y=%h want c=1 id=2 y=00", rsp_carry, rsp_id, rsp_y);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got rsp_valid=%b want 0", rsp_valid); end
    next_cycle();
  endtask

  task automatic test_wrap();
    // Pointer sits at 3 after the overflow case: 3 is idle, so 0 wins, then 2.
    req_valid = 4'b0101;
    rand_ops();
    push(0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b want 0001", req_ready); end
    next_cycle();
    rand_ops();
    push(2);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_second: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    // Requester 3 alone moves the pointer back to 0.
    req_valid = 4'b1000;
    rand_ops();
    push(3);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL fair_pre: got %b want 1000", req_ready); end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req_valid = 4'b1111;
      rand_ops();
      push(k % N);
      want = N'(1) << (k % N);
      @(negedge clk);
      checks++;
      if (req_ready !== want) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, req_ready, want); end
    end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_y;
    // Pointer is 1 here.
    req_valid = 4'b0010;
    rand_ops();
    held_y = req_a[1] + req_b[1];
    rsp_ready = 1'b0;
    push(1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_fill: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_y !== held_y) begin
        errors++;
        $display("FAIL bp_hold%0d: got ready=%b v=%b y=%h want ready=0000 v=1 y=%h", k, req_ready, rsp_valid, rsp_y, held_y);
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
    push(2);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b want 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    // Pointer is 3; requester 2 fills the slot and the result is then discarded.
    req_valid = 4'b0100;
    rand_ops();
    rsp_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_full: got rsp_valid=%b want 1", rsp_valid); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_carry, rsp_id, rsp_y} !== '0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_async: got v=%b c=%b id=%0d y=%h ready=%b want all 0",
               rsp_valid, rsp_carry, rsp_id, rsp_y, req_ready);
    end
    sb.delete();
    $display("reset asserted mid-operation: rsp_valid=%b", rsp_valid);
    next_cycle();
    reset = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    rand_ops();
    push(1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain: got rsp_valid=%b want 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending results want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
